bf16_accum: RTL and testbench
=============================

Name: bf16_accum

Overview:
- Sequential bfloat16 reduction engine for the FPU.
- Accepts a job (initial value, element count, add/sub mode), then takes a valid/ready stream of bf16 elements and sums each into an accumulator register through one instance of Add_Sub.
- Presents the final sum on a valid/ready output port.
- Sits between the core-side FPU request logic (upstream) and Add_Sub, which it drives and whose result it registers (downstream).

Parameters:
CNT_W, 8, width of len_i and count_o; max job length 2^CNT_W-1 elements

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  job start pulse, honoured only in IDLE
len_i  input  CNT_W  element count for the job, sampled on start
init_i  input  16  initial accumulator value (bf16), sampled on start
sub_i  input  1  1 = subtract every element, sampled on start
in_valid_i  input  1  element valid
in_ready_o  output  1  element ready
in_data_i  input  16  bf16 element
out_valid_o  output  1  result valid
out_ready_i  input  1  result ready
out_data_o  output  16  accumulated bf16 result
busy_o  output  1  high in any state except IDLE
count_o  output  CNT_W  elements accepted in current job

Behaviour:
- Reset (rst_i sampled high at an edge): state=IDLE; acc_q, b_q, remaining, count_o, out_data_o cleared to 0; b_vld=0; in_ready_o=0; out_valid_o=0; busy_o=0.
- Reset mid-job discards all accepted elements and any pending result. No output handshake occurs.
- Registers:
  - acc_q[15:0]
  - b_q[15:0] plus b_vld
  - remaining[CNT_W-1:0]
  - sub_q
  - count_q
  - state
- Adder: Add_Sub with A=acc_q, B=b_q. No other adder use.
- Element handshake: in_valid_i & in_ready_o at an edge.
  - b_q <= sub_q ? {~in_data_i[15], in_data_i[14:0]} : in_data_i.
  - b_vld <= 1; remaining decrements; count_q increments.
  - Without a handshake, b_vld <= 0.
- Whenever b_vld=1 at an edge: acc_q <= Add_Sub result.
  - Throughput is 1 element/cycle.
  - acc_q is never written by the adder when b_vld=0.
- States:
  - IDLE:
    - in_ready_o=0, out_valid_o=0.
    - start_i with len_i!=0: acc_q<=init_i, remaining<=len_i, sub_q<=sub_i, count_q<=0, go to RUN.
    - start_i with len_i==0: acc_q<=init_i, count_q<=0, go to DONE.
  - RUN:
    - in_ready_o = (remaining!=0), driven from registers only (no in_valid_i→in_ready_o path).
    - When the last element handshakes (remaining 1→0), go to DRAIN.
  - DRAIN:
    - in_ready_o=0.
    - One cycle: the adder absorbs the last b_q, then go to DONE.
  - DONE:
    - out_valid_o=1, out_data_o=acc_q, held stable until out_ready_i.
    - On the out handshake, go to IDLE.
- start_i is ignored in every state except IDLE, including the cycle of the out handshake.
- in_valid_i is ignored when in_ready_o=0. Gaps in in_valid_i are legal in RUN.
- Latency:
  - out_valid_o rises in the cycle after the edge following the last element handshake (2 edges after that handshake).
  - For len 0: out_valid_o is high the cycle after the start edge.
- Special values follow Add_Sub semantics, which this block does not alter:
  - NaN persists once in acc_q.
  - +Inf plus -Inf yields 0x7FC0.
  - In sub mode the sign flip is applied before Add_Sub, so subtracting +Inf behaves as adding -Inf.
- count_o = count_q; it holds its final value through DONE and IDLE until the next start.
- busy_o is high in RUN, DRAIN and DONE.

Test Plan:
- Back-to-back add: init 0x0000, len 4, sub 0, in_valid held high, four elements of 0x3F80 → in_ready_o high for exactly 4 cycles; out_data_o=0x4080 with out_valid_o 2 edges after the 4th handshake; count_o=4.
- Subtract mode: init 0x4120, len 2, sub 1, elements 0x4040 then 0x3F80 → out_data_o=0x40C0 (6.0).
- Zero-length job: start with len 0, init 0x4049 → in_ready_o never high; out_valid_o high the next cycle with 0x4049; count_o=0.
- Bubbles and backpressure, with 3-cycle gaps in in_valid_i:
  - init 0x0000, len 3, elements 0x3F80, 0xBF80, 0x4000 → result 0x4000.
  - Hold out_ready_i low for 5 cycles → data and valid stable.
  - start_i pulsed during DONE → ignored.
- Special values: init 0x0000, len 2, elements 0x7F80 then 0xFF80 → out_data_o=0x7FC0. In a separate job, a NaN element followed by 0x3F80 → 0x7FC0.
- Reset mid-RUN: len 4, rst_i after 2 handshakes → next cycle all outputs at reset values and busy_o=0. A following job with init 0x3F80, len 1, element 0x3F80 → 0x4000, unaffected by the aborted job.

Source files
------------

// File: rtl/bf16_accum.sv
// Sequential bfloat16 reduction engine: sums a stream of bf16 elements into an
// accumulator through a single Add_Sub instance and presents the result on a valid/ready port.

module Add_Sub (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum_c
);
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_eff_sub, w_sticky, w_rnd;
    logic [15:0] w_big, w_sml;
    logic [7:0]  w_m_big, w_m_sml, w_d, w_m8;
    logic [10:0] w_x, w_y_ext, w_y, w_mask;
    logic [11:0] w_s, w_t;
    logic [3:0]  w_lz;
    logic [9:0]  w_exp, w_exp_r;

    assign w_a_nan = (&i_a[14:7]) & (|i_a[6:0]);
    assign w_b_nan = (&i_b[14:7]) & (|i_b[6:0]);
    assign w_a_inf = (&i_a[14:7]) & ~(|i_a[6:0]);
    assign w_b_inf = (&i_b[14:7]) & ~(|i_b[6:0]);

    // Subnormal operands are treated as zero; larger magnitude goes first.
    always_comb begin
        w_swap    = i_b[14:0] > i_a[14:0];
        w_big     = w_swap ? i_b : i_a;
        w_sml     = w_swap ? i_a : i_b;
        w_m_big   = (w_big[14:7] == 8'd0) ? 8'd0 : {1'b1, w_big[6:0]};
        w_m_sml   = (w_sml[14:7] == 8'd0) ? 8'd0 : {1'b1, w_sml[6:0]};
        w_d       = w_big[14:7] - w_sml[14:7];
        w_eff_sub = w_big[15] ^ w_sml[15];
        w_x       = {w_m_big, 3'b000};
        w_y_ext   = {w_m_sml, 3'b000};
        w_mask    = ~(11'h7FF << w_d);
        if (w_d >= 8'd11) begin
            w_y      = 11'd0;
            w_sticky = |w_m_sml;
        end else begin
            w_y      = w_y_ext >> w_d;
            w_sticky = |(w_y_ext & w_mask);
        end
        w_y[0] = w_y[0] | w_sticky;
        w_s = w_eff_sub ? ({1'b0, w_x} - {1'b0, w_y}) : ({1'b0, w_x} + {1'b0, w_y});
    end

    // Normalise, then round to nearest even on guard / sticky.
    always_comb begin
        w_lz = 4'd12;
        for (int i = 0; i < 12; i++) begin
            if (w_s[i]) w_lz = 4'(11 - i);
        end
        w_t   = w_s << w_lz;
        w_exp = {2'b00, w_big[14:7]} + 10'd1 - {6'd0, w_lz};
        w_rnd = w_t[3] & (w_t[4] | (|w_t[2:0]));
        w_m8  = {1'b0, w_t[10:4]} + 8'(w_rnd);
        w_exp_r = w_m8[7] ? (w_exp + 10'd1) : w_exp;

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[15] != i_b[15])))
            o_sum_c = 16'h7FC0;
        else if (w_a_inf)
            o_sum_c = i_a;
        else if (w_b_inf)
            o_sum_c = i_b;
        else if (!w_t[11])
            o_sum_c = {i_a[15] & i_b[15], 15'd0};
        else if (w_exp_r[9] || (w_exp_r == 10'd0))
            o_sum_c = {w_big[15], 15'd0};
        else if (w_exp_r[8:0] >= 9'd255)
            o_sum_c = {w_big[15], 8'hFF, 7'd0};
        else
            o_sum_c = {w_big[15], w_exp_r[7:0], w_m8[6:0]};
    end
endmodule

module bf16_accum #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [15:0]      init_i,
    input  logic             sub_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [15:0]      out_data_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_acc, w_acc_nxt, r_b, w_b_nxt, w_sum;
    logic             r_b_vld, w_b_vld_nxt, r_sub, w_sub_nxt;
    logic [CNT_W-1:0] r_rem, w_rem_nxt, r_count, w_count_nxt;
    logic             r_in_ready, w_in_ready_nxt, r_out_valid, w_out_valid_nxt;
    logic             r_busy, w_busy_nxt, w_hs;

    Add_Sub u_add_sub (
        .i_a     (r_acc),
        .i_b     (r_b),
        .o_sum_c (w_sum)
    );

    assign w_hs = r_in_ready & in_valid_i;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_b_vld ? w_sum : r_acc;
        w_b_nxt     = r_b;
        w_b_vld_nxt = 1'b0;
        w_rem_nxt   = r_rem;
        w_sub_nxt   = r_sub;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_acc_nxt   = init_i;
                    w_count_nxt = '0;
                    if (len_i != '0) begin
                        w_rem_nxt   = len_i;
                        w_sub_nxt   = sub_i;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (w_hs) begin
                    w_b_nxt     = r_sub ? {~in_data_i[15], in_data_i[14:0]} : in_data_i;
                    w_b_vld_nxt = 1'b1;
                    w_rem_nxt   = r_rem - CNT_W'(1);
                    w_count_nxt = r_count + CNT_W'(1);
                    if (r_rem == CNT_W'(1)) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE: begin
                if (out_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Handshake outputs are registered from the state they will describe.
        w_in_ready_nxt  = (w_state_nxt == S_RUN) && (w_rem_nxt != '0);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_b         <= '0;
            r_b_vld     <= 1'b0;
            r_rem       <= '0;
            r_sub       <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_b         <= w_b_nxt;
            r_b_vld     <= w_b_vld_nxt;
            r_rem       <= w_rem_nxt;
            r_sub       <= w_sub_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_acc;
    assign busy_o      = r_busy;
    assign count_o     = r_count;
endmodule

// File: tb/tb_bf16_accum.sv
// Self-checking bench for bf16_accum: directed scenarios plus random jobs checked
// against a real-arithmetic reference rounded to bf16 after every addition.

module tb_bf16_accum;
    localparam int unsigned CNT_W = 8;

    logic             clk_i = 1'b0;
    logic             rst_i, start_i, sub_i, in_valid_i, in_ready_o;
    logic             out_valid_o, out_ready_i, busy_o;
    logic [CNT_W-1:0] len_i, count_o;
    logic [15:0]      init_i, in_data_i, out_data_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] elems[$];
    int          ready_cycles, hs_lat;
    bit          job_ok;

    bf16_accum #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .init_i(init_i), .sub_i(sub_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .in_data_i(in_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .busy_o(busy_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic real bf_to_real(input logic [15:0] b);
        real v;
        int  e;
        e = int'(b[14:7]);
        if (e == 0) return 0.0;
        v = (1.0 + real'(int'(b[6:0])) / 128.0) * (2.0 ** real'(e - 127));
        return b[15] ? -v : v;
    endfunction

    // Round a double to the nearest bf16, ties to even (normal range only).
    function automatic logic [15:0] real_to_bf(input real r);
        logic [63:0] d;
        logic [44:0] rest, half;
        logic [7:0]  m;
        int          be;
        if (r == 0.0) return 16'h0000;
        d    = $realtobits(r);
        be   = int'(d[62:52]) - 1023 + 127;
        m    = {1'b0, d[51:45]};
        rest = d[44:0];
        half = 45'h1 << 44;
        if (rest > half || (rest == half && m[0])) m = m + 8'd1;
        if (m[7]) begin
            be = be + 1;
            m  = 8'd0;
        end
        return {d[63], 8'(be), m[6:0]};
    endfunction

    function automatic logic [15:0] rand_val();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(118, 136)), 7'($urandom_range(0, 127))};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Start a job, stream elems[] with `gap` idle cycles after each handshake,
    // and return once out_valid_o is seen (bounded).
    task automatic run_job(input logic [15:0] init, input int len, input bit sub, input int gap);
        int idx, gcnt, budget, lat;
        bit hs;
        start_i = 1'b1;
        init_i  = init;
        len_i   = CNT_W'(len);
        sub_i   = sub;
        step();
        start_i = 1'b0;
        idx = 0; gcnt = 0; budget = 0; lat = -1; ready_cycles = 0;
        while (!out_valid_o && budget < 500) begin
            if (in_ready_o) ready_cycles++;
            in_valid_i = (idx < len) && (gcnt == 0);
            in_data_i  = (idx < len) ? elems[idx] : 16'h0000;
            hs = in_valid_i && in_ready_o;
            step();
            if (lat >= 0) lat++;
            if (hs) begin
                idx++;
                gcnt = gap;
                lat  = 1;
            end else if (gcnt > 0) begin
                gcnt--;
            end
            budget++;
        end
        in_valid_i = 1'b0;
        hs_lat = lat;
        job_ok = out_valid_o;
    endtask

    task automatic take_result();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_checks++; if (count_o !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        n_checks++; if (out_data_o !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", out_data_o); end
    endtask

    task automatic test_back_to_back();
        elems = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
        run_job(16'h0000, 4, 1'b0, 0);
        n_checks++; if (job_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got %b expected 1", job_ok); end
        n_checks++; if (ready_cycles != 4) begin n_fail++; $display("FAIL b2b_ready_cycles: got %0d expected 4", ready_cycles); end
        n_checks++; if (hs_lat != 2) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 2", hs_lat); end
        n_checks++; if (out_data_o !== 16'h4080) begin n_fail++; $display("FAIL b2b_data: got %h expected 4080", out_data_o); end
        n_checks++; if (count_o !== CNT_W'(4)) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", count_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_done: got %b expected 1", busy_o); end
        take_result();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_after: got %b expected 0", out_valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %b expected 0", busy_o); end
        n_checks++; if (count_o !== CNT_W'(4)) begin n_fail++; $display("FAIL b2b_count_idle: got %0d expected 4", count_o); end
    endtask

    task automatic test_sub();
        elems = '{16'h4040, 16'h3F80};
        run_job(16'h4120, 2, 1'b1, 0);
        n_checks++; if (out_data_o !== 16'h40C0) begin n_fail++; $display("FAIL sub_data: got %h expected 40c0", out_data_o); end
        n_checks++; if (count_o !== CNT_W'(2)) begin n_fail++; $display("FAIL sub_count: got %0d expected 2", count_o); end
        take_result();
    endtask

    task automatic test_zero_len();
        start_i = 1'b1;
        len_i   = '0;
        init_i  = 16'h4049;
        sub_i   = 1'b0;
        step();
        start_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL zlen_valid: got %b expected 1", out_valid_o); end
        n_checks++; if (out_data_o !== 16'h4049) begin n_fail++; $display("FAIL zlen_data: got %h expected 4049", out_data_o); end
        n_checks++; if (count_o !== '0) begin n_fail++; $display("FAIL zlen_count: got %0d expected 0", count_o); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL zlen_in_ready: got %b expected 0", in_ready_o); end
            step();
        end
        take_result();
    endtask

    task automatic test_bubbles_backpressure();
        elems = '{16'h3F80, 16'hBF80, 16'h4000};
        run_job(16'h0000, 3, 1'b0, 3);
        n_checks++; if (job_ok !== 1'b1) begin n_fail++; $display("FAIL bub_timeout: got %b expected 1", job_ok); end
        n_checks++; if (out_data_o !== 16'h4000) begin n_fail++; $display("FAIL bub_data: got %h expected 4000", out_data_o); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start_i = 1'b1;
                len_i   = CNT_W'(5);
                init_i  = 16'h1234;
            end
            step();
            start_i = 1'b0;
            n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: got %b expected 1", out_valid_o); end
            n_checks++; if (out_data_o !== 16'h4000) begin n_fail++; $display("FAIL bp_data_hold: got %h expected 4000", out_data_o); end
        end
        n_checks++; if (count_o !== CNT_W'(3)) begin n_fail++; $display("FAIL bp_count: got %0d expected 3", count_o); end
        // A start coinciding with the output handshake must also be dropped.
        out_ready_i = 1'b1;
        start_i     = 1'b1;
        step();
        out_ready_i = 1'b0;
        start_i     = 1'b0;
        step();
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL hs_start_busy: got %b expected 0", busy_o); end
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL hs_start_ready: got %b expected 0", in_ready_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL hs_start_valid: got %b expected 0", out_valid_o); end
    endtask

    task automatic test_special();
        elems = '{16'h7F80, 16'hFF80};
        run_job(16'h0000, 2, 1'b0, 0);
        n_checks++; if (out_data_o !== 16'h7FC0) begin n_fail++; $display("FAIL inf_minus_inf: got %h expected 7fc0", out_data_o); end
        take_result();
        elems = '{16'h7FC1, 16'h3F80};
        run_job(16'h0000, 2, 1'b0, 1);
        n_checks++; if (out_data_o !== 16'h7FC0) begin n_fail++; $display("FAIL nan_persist: got %h expected 7fc0", out_data_o); end
        take_result();
        elems = '{16'h7F80};
        run_job(16'h7F80, 1, 1'b1, 0);
        n_checks++; if (out_data_o !== 16'h7FC0) begin n_fail++; $display("FAIL sub_inf: got %h expected 7fc0", out_data_o); end
        take_result();
    endtask

    task automatic test_reset_mid_run();
        start_i = 1'b1;
        len_i   = CNT_W'(4);
        init_i  = 16'h4000;
        sub_i   = 1'b0;
        step();
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 16'h3F80;
        step();
        step();
        n_checks++; if (count_o !== CNT_W'(2)) begin n_fail++; $display("FAIL mid_count_pre: got %0d expected 2", count_o); end
        in_valid_i = 1'b0;
        rst_i      = 1'b1;
        step();
        rst_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy_o); end
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 0", in_ready_o); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", out_valid_o); end
        n_checks++; if (count_o !== '0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", count_o); end
        n_checks++; if (out_data_o !== 16'h0000) begin n_fail++; $display("FAIL mid_data: got %h expected 0000", out_data_o); end
        elems = '{16'h3F80};
        run_job(16'h3F80, 1, 1'b0, 0);
        n_checks++; if (out_data_o !== 16'h4000) begin n_fail++; $display("FAIL post_reset_job: got %h expected 4000", out_data_o); end
        n_checks++; if (count_o !== CNT_W'(1)) begin n_fail++; $display("FAIL post_reset_count: got %0d expected 1", count_o); end
        take_result();
    endtask

    task automatic test_random();
        logic [15:0] init, acc, e;
        int          len, gap, hold;
        bit          sub;
        for (int j = 0; j < 25; j++) begin
            len  = $urandom_range(1, 8);
            sub  = 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 2);
            hold = $urandom_range(0, 3);
            init = rand_val();
            acc  = init;
            elems.delete();
            for (int k = 0; k < len; k++) begin
                e = rand_val();
                elems.push_back(e);
                if (sub) e = e ^ 16'h8000;
                acc = real_to_bf(bf_to_real(acc) + bf_to_real(e));
            end
            run_job(init, len, sub, gap);
            for (int h = 0; h < hold; h++) step();
            n_checks++; if (job_ok !== 1'b1) begin n_fail++; $display("FAIL rnd_timeout job %0d: got %b expected 1", j, job_ok); end
            n_checks++; if (out_data_o !== acc) begin n_fail++; $display("FAIL rnd_data job %0d: got %h expected %h", j, out_data_o, acc); end
            n_checks++; if (count_o !== CNT_W'(len)) begin n_fail++; $display("FAIL rnd_count job %0d: got %0d expected %0d", j, count_o, len); end
            take_result();
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        len_i       = '0;
        init_i      = 16'h0000;
        sub_i       = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 16'h0000;
        out_ready_i = 1'b0;
        test_reset();
        test_back_to_back();
        test_sub();
        test_zero_len();
        test_bubbles_backpressure();
        test_special();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
